vedic_mac_pipe: RTL and testbench
=================================

VEDIC_MAC_PIPE -- requirements
Module: vedic_mac_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width; legal values are 8, 16 and 32.
REQ-002 SHALL have parameter ACC_WIDTH, default 2*WIDTH+8, giving the accumulator and result width; it SHALL be at least 2*WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input sample is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the sample this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port b, input, WIDTH bits: multiplier.
REQ-009 SHALL have port signed_mode, input, 1 bit: 1 means a and b are two's complement; sampled with the operands.
REQ-010 SHALL have port acc_en, input, 1 bit: the sample accumulates; sampled with the operands.
REQ-011 SHALL have port acc_clr, input, 1 bit: the accumulator clears before this sample is added; sampled with the operands.
REQ-012 SHALL have port out_valid, output, 1 bit: result holds a completed sample.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 SHALL have port result, output, ACC_WIDTH bits: the product or the accumulator value.
REQ-015 SHALL have port acc_ovf, output, 1 bit: sticky accumulator-overflow flag.

Function
REQ-016 SHALL accept a sample when in_valid and in_ready are both 1; SHALL deliver a sample when out_valid and out_ready are both 1.
REQ-017 SHALL use a 3-stage pipeline.
- S1: register the operand magnitudes and the product sign (sign_a XOR sign_b when signed_mode=1, else 0), plus the acc_en and acc_clr flags.
- S2: register the four (WIDTH/2)x(WIDTH/2) vedic quadrant products: LL, HL, LH, HH.
- S3: combine the products, negate if required, accumulate, and write the output register.
REQ-018 Latency SHALL be exactly 3 cycles from acceptance to out_valid=1 when out_ready is held at 1; throughput SHALL be 1 sample per cycle.
REQ-019 SHALL advance all stages together on adv = !out_valid | out_ready; in_ready SHALL equal adv; all stage registers and valid bits SHALL hold when adv=0.
REQ-020 SHALL form the magnitude product in S3 as HH<<WIDTH + (HL+LH)<<(WIDTH/2) + LL.
- The cross sum SHALL be WIDTH+1 bits wide.
- The magnitude product SHALL be exactly 2*WIDTH bits with no truncation.
REQ-021 In signed mode, operand magnitude SHALL be the two's-complement absolute value, held in WIDTH bits.
- -2^(WIDTH-1) SHALL map to 2^(WIDTH-1).
- The product SHALL be negated when the sign bit is 1, then sign-extended to ACC_WIDTH.
- Unsigned products SHALL be zero-extended to ACC_WIDTH.
REQ-022 When the sample's acc_en=0, the output stage SHALL load result with the extended product and SHALL leave the accumulator and acc_ovf unchanged.
REQ-023 When the sample's acc_en=1, the output stage SHALL compute acc_new = (acc_clr ? 0 : acc) + product in ACC_WIDTH bits, wrapping modulo 2^ACC_WIDTH.
- acc and result SHALL both load acc_new.
REQ-024 acc_ovf SHALL set when an acc_en=1 addition overflows.
- Signed samples: the operands' signs agree and the sum's sign differs.
- Unsigned samples: carry out of bit ACC_WIDTH-1.
- acc_ovf SHALL clear when a sample with acc_clr=1 and acc_en=1 is loaded, and SHALL then set if that same addition overflows.
REQ-025 acc_clr with acc_en=0 SHALL have no effect.
REQ-026 A sample accepted in the same cycle that another sample is delivered SHALL be handled without loss or duplication.
REQ-027 result and acc_ovf SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-028 While rst_n=0, all valid bits, out_valid, result, the accumulator, acc_ovf and all stage data registers SHALL be 0, independent of clk.
REQ-029 in_ready SHALL be 1 while out_valid=0, including during reset.
REQ-030 Samples in flight when reset asserts SHALL be discarded and never delivered.
REQ-031 The first sample accepted after rst_n rises SHALL appear 3 cycles later.

Verification (WIDTH=16, ACC_WIDTH=40)
REQ-032 Bench SHALL apply unsigned a=0xFFFF, b=0xFFFF, acc_en=0 -> result=0x00FFFE0001 exactly 3 cycles after acceptance.
REQ-033 Bench SHALL apply signed 0x8000*0x8000 -> result=0x0040000000, and signed 0xFFFF*0x0003 -> result=0xFFFFFFFFFD.
REQ-034 Bench SHALL apply unsigned 2*3 (acc_clr=1), then 4*5, then 6*7, all acc_en=1 -> results 6, 26, 68 on consecutive cycles.
REQ-035 Bench SHALL stream 4 back-to-back samples and hold out_ready=0 for 5 cycles after the first out_valid.
- Required: in_ready=0 while stalled, result held, all 4 products delivered in order with none lost.
REQ-036 Bench SHALL accumulate unsigned 0xFFFF*0xFFFF 300 times, then issue acc_clr=1 with 1*1.
- Required: acc_ovf=1 after wrap, result wraps modulo 2^40; then result=1 and acc_ovf=0.
REQ-037 Bench SHALL pulse rst_n low for 1 cycle with 2 samples in flight.
- Required: outputs read 0 immediately, neither sample is delivered, and the next sample appears 3 cycles after acceptance.

Source files
------------

// File: rtl/vedic_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vedic_mac_pipe : 3-stage multiply-accumulate, vedic quadrant multiplier     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module vedic_mac_pipe #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 2*WIDTH+8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 acc_en,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 acc_ovf
);

    localparam int c_half = WIDTH/2;
    localparam logic [WIDTH-1:0]     c_one_w   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0] c_one_acc = {{(ACC_WIDTH-1){1'b0}}, 1'b1};

    logic w_adv;

    // S1 state
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_mag_a;
    logic [WIDTH-1:0] r_s1_mag_b;
    logic             r_s1_neg;
    logic             r_s1_signed;
    logic             r_s1_acc_en;
    logic             r_s1_acc_clr;

    // S2 state
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_ll;
    logic [WIDTH-1:0] r_s2_hl;
    logic [WIDTH-1:0] r_s2_lh;
    logic [WIDTH-1:0] r_s2_hh;
    logic             r_s2_neg;
    logic             r_s2_signed;
    logic             r_s2_acc_en;
    logic             r_s2_acc_clr;

    // S3 / output state
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_result;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_acc_ovf;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg;
    logic [c_half-1:0]    w_a_lo;
    logic [c_half-1:0]    w_a_hi;
    logic [c_half-1:0]    w_b_lo;
    logic [c_half-1:0]    w_b_hi;
    logic [WIDTH-1:0]     w_ll;
    logic [WIDTH-1:0]     w_hl;
    logic [WIDTH-1:0]     w_lh;
    logic [WIDTH-1:0]     w_hh;
    logic [WIDTH:0]       w_cross;
    logic [2*WIDTH-1:0]   w_mag;
    logic [ACC_WIDTH-1:0] w_prod_z;
    logic [ACC_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf;
    logic                 w_ovf_next;

    assign w_adv     = !r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign acc_ovf   = r_acc_ovf;

    // Two's-complement magnitude; the most negative value wraps onto 2^(WIDTH-1).
    assign w_mag_a = (signed_mode && a[WIDTH-1]) ? (~a + c_one_w) : a;
    assign w_mag_b = (signed_mode && b[WIDTH-1]) ? (~b + c_one_w) : b;
    assign w_neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_mag_a   <= '0;
            r_s1_mag_b   <= '0;
            r_s1_neg     <= 1'b0;
            r_s1_signed  <= 1'b0;
            r_s1_acc_en  <= 1'b0;
            r_s1_acc_clr <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_mag_a   <= w_mag_a;
            r_s1_mag_b   <= w_mag_b;
            r_s1_neg     <= w_neg;
            r_s1_signed  <= signed_mode;
            r_s1_acc_en  <= acc_en;
            r_s1_acc_clr <= acc_clr;
        end
    end

    // Urdhva-Tiryagbhyam split: vertical (LL, HH) and crosswise (HL, LH) partials.
    assign w_a_lo = r_s1_mag_a[c_half-1:0];
    assign w_a_hi = r_s1_mag_a[WIDTH-1:c_half];
    assign w_b_lo = r_s1_mag_b[c_half-1:0];
    assign w_b_hi = r_s1_mag_b[WIDTH-1:c_half];
    assign w_ll   = WIDTH'(w_a_lo) * WIDTH'(w_b_lo);
    assign w_hl   = WIDTH'(w_a_hi) * WIDTH'(w_b_lo);
    assign w_lh   = WIDTH'(w_a_lo) * WIDTH'(w_b_hi);
    assign w_hh   = WIDTH'(w_a_hi) * WIDTH'(w_b_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_ll      <= '0;
            r_s2_hl      <= '0;
            r_s2_lh      <= '0;
            r_s2_hh      <= '0;
            r_s2_neg     <= 1'b0;
            r_s2_signed  <= 1'b0;
            r_s2_acc_en  <= 1'b0;
            r_s2_acc_clr <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid   <= r_s1_valid;
            r_s2_ll      <= w_ll;
            r_s2_hl      <= w_hl;
            r_s2_lh      <= w_lh;
            r_s2_hh      <= w_hh;
            r_s2_neg     <= r_s1_neg;
            r_s2_signed  <= r_s1_signed;
            r_s2_acc_en  <= r_s1_acc_en;
            r_s2_acc_clr <= r_s1_acc_clr;
        end
    end

    // {HH,LL} equals HH<<WIDTH + LL since LL never exceeds WIDTH bits.
    assign w_cross  = (WIDTH+1)'(r_s2_hl) + (WIDTH+1)'(r_s2_lh);
    assign w_mag    = {r_s2_hh, r_s2_ll} + ((2*WIDTH)'(w_cross) << c_half);
    assign w_prod_z = ACC_WIDTH'(w_mag);
    assign w_prod   = r_s2_neg ? (~w_prod_z + c_one_acc) : w_prod_z;

    assign w_base     = r_s2_acc_clr ? '0 : r_acc;
    assign w_sum      = {1'b0, w_base} + {1'b0, w_prod};
    assign w_ovf      = r_s2_signed
                        ? ((w_base[ACC_WIDTH-1] == w_prod[ACC_WIDTH-1]) &&
                           (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]))
                        : w_sum[ACC_WIDTH];
    assign w_ovf_next = (r_s2_acc_clr ? 1'b0 : r_acc_ovf) | w_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                if (r_s2_acc_en) begin
                    r_acc     <= w_sum[ACC_WIDTH-1:0];
                    r_result  <= w_sum[ACC_WIDTH-1:0];
                    r_acc_ovf <= w_ovf_next;
                end else begin
                    r_result  <= w_prod;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vedic_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vedic_mac_pipe : scoreboard bench for vedic_mac_pipe (WIDTH=16)          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_vedic_mac_pipe;

    localparam int WIDTH     = 16;
    localparam int ACC_WIDTH = 40;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 acc_en;
    logic                 acc_clr;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] result;
    logic                 acc_ovf;

    vedic_mac_pipe #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .acc_clr     (acc_clr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .acc_ovf     (acc_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit lat_check = 1'b1;

    logic [ACC_WIDTH-1:0] exp_res_q[$];
    bit                   exp_ovf_q[$];
    int                   acc_cyc_q[$];
    logic [ACC_WIDTH-1:0] got_res_q[$];
    bit                   got_ovf_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor + reference model: expected values pushed on acceptance, popped on delivery.
    initial begin
        logic [ACC_WIDTH-1:0] p, base, er, held_res, m_acc;
        logic [ACC_WIDTH:0]   s;
        longint               sp;
        bit                   o, eo, m_ovf, held_ovf, was_stall;
        int                   ac;
        m_acc = '0; m_ovf = 1'b0; was_stall = 1'b0; held_res = '0; held_ovf = 1'b0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_res_q.delete(); exp_ovf_q.delete(); acc_cyc_q.delete();
                m_acc = '0; m_ovf = 1'b0; was_stall = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    got_res_q.push_back(result);
                    got_ovf_q.push_back(acc_ovf);
                    if (exp_res_q.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        er = exp_res_q.pop_front();
                        eo = exp_ovf_q.pop_front();
                        ac = acc_cyc_q.pop_front();
                        check("result", result, er);
                        check("acc_ovf", acc_ovf, eo);
                        if (lat_check) check("latency", 64'(cyc - ac), 3);
                    end
                    was_stall = 1'b0;
                end else if (out_valid) begin
                    check("stall_in_ready", in_ready, 0);
                    if (was_stall) begin
                        check("stall_result_held", result, held_res);
                        check("stall_ovf_held", acc_ovf, held_ovf);
                    end
                    held_res  = result;
                    held_ovf  = acc_ovf;
                    was_stall = 1'b1;
                end else begin
                    was_stall = 1'b0;
                end
                if (in_valid && in_ready) begin
                    if (signed_mode) begin
                        sp = longint'($signed(a)) * longint'($signed(b));
                        p  = sp[ACC_WIDTH-1:0];
                    end else begin
                        p = ACC_WIDTH'(a) * ACC_WIDTH'(b);
                    end
                    if (acc_en) begin
                        base = acc_clr ? '0 : m_acc;
                        s    = {1'b0, base} + {1'b0, p};
                        o    = signed_mode ? ((base[ACC_WIDTH-1] == p[ACC_WIDTH-1]) &&
                                              (s[ACC_WIDTH-1] != base[ACC_WIDTH-1]))
                                           : s[ACC_WIDTH];
                        m_ovf = (acc_clr ? 1'b0 : m_ovf) | o;
                        m_acc = s[ACC_WIDTH-1:0];
                        exp_res_q.push_back(m_acc);
                    end else begin
                        exp_res_q.push_back(p);
                    end
                    exp_ovf_q.push_back(m_ovf);
                    acc_cyc_q.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb,
                        input bit sm, input bit en, input bit clr);
        int n = 0;
        in_valid = 1'b1; a = sa; b = sb; signed_mode = sm; acc_en = en; acc_clr = clr;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n >= 100) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_res_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", exp_res_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] big;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        signed_mode = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_acc_ovf", acc_ovf, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Largest unsigned product, no accumulation
        got_res_q.delete(); got_ovf_q.delete();
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        drain();
        check("u_max_count", got_res_q.size(), 1);
        check("u_max_result", got_res_q[0], 40'h00FFFE0001);

        // Signed corner cases
        got_res_q.delete(); got_ovf_q.delete();
        send(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0003, 1'b1, 1'b0, 1'b0);
        drain();
        check("s_minmin", got_res_q[0], 40'h0040000000);
        check("s_neg1x3", got_res_q[1], 40'hFFFFFFFFFD);

        // Back-to-back accumulation; acc_clr without acc_en must be ignored
        got_res_q.delete(); got_ovf_q.delete();
        send(16'd2, 16'd3, 1'b0, 1'b1, 1'b1);
        send(16'd4, 16'd5, 1'b0, 1'b1, 1'b0);
        send(16'd6, 16'd7, 1'b0, 1'b1, 1'b0);
        send(16'd3, 16'd3, 1'b0, 1'b0, 1'b1);
        send(16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
        drain();
        check("acc_6",  got_res_q[0], 40'd6);
        check("acc_26", got_res_q[1], 40'd26);
        check("acc_68", got_res_q[2], 40'd68);
        check("clr_noacc", got_res_q[3], 40'd9);
        check("acc_69", got_res_q[4], 40'd69);

        // Signed accumulation
        got_res_q.delete(); got_ovf_q.delete();
        send(16'hFFFF, 16'h0003, 1'b1, 1'b1, 1'b1);
        send(16'h0005, 16'h0004, 1'b1, 1'b1, 1'b0);
        drain();
        check("sacc_m3", got_res_q[0], 40'hFFFFFFFFFD);
        check("sacc_17", got_res_q[1], 40'd17);

        // Stream 4 samples and stall the consumer for 5 cycles
        got_res_q.delete(); got_ovf_q.delete();
        lat_check = 1'b0;
        fork
            begin
                send(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0);
                send(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0);
                send(16'h0505, 16'h0606, 1'b0, 1'b0, 1'b0);
                send(16'h0707, 16'h0808, 1'b0, 1'b0, 1'b0);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (out_valid) break;
                end
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        lat_check = 1'b1;
        check("stall_count", got_res_q.size(), 4);

        // 300-fold accumulation wraps the 40-bit accumulator
        got_res_q.delete(); got_ovf_q.delete();
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i < 300; i++) send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        drain();
        big = 64'd300 * 64'hFFFE0001;
        check("wrap_count", got_res_q.size(), 300);
        check("wrap_result", got_res_q[299], {24'b0, big[39:0]});
        check("wrap_ovf", got_ovf_q[299], 1);
        check("pre_wrap_ovf", got_ovf_q[255], 0);
        got_res_q.delete(); got_ovf_q.delete();
        send(16'd1, 16'd1, 1'b0, 1'b1, 1'b1);
        drain();
        check("clr_result", got_res_q[0], 40'd1);
        check("clr_ovf", got_ovf_q[0], 0);

        // Reset pulse with two samples in flight
        got_res_q.delete(); got_ovf_q.delete();
        send(16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0);
        send(16'h0020, 16'h0020, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_acc_ovf", acc_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_out", out_valid, 0);
        end
        check("rst_flushed", got_res_q.size(), 0);
        @(posedge clk); #1;
        send(16'd3, 16'd5, 1'b0, 1'b0, 1'b0);
        drain();
        check("post_rst_count", got_res_q.size(), 1);
        check("post_rst_result", got_res_q[0], 40'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
